// File: rtl/jtframe_obj_sched.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_obj_sched
// Purpose  : Object line scheduler. On each horizontal blank it walks the
//            object attribute table, and for every object overlapping the
//            line being prepared it issues one draw request to the pixel
//            drawer. It caps the number of objects per line and flags overflow.
// Revision : 1.0  initial release
// ============================================================================
module jtframe_obj_sched #(
  parameter int OBJW   = 7,
  parameter int VW     = 8,
  parameter int HW     = 9,
  parameter int CW     = 12,
  parameter int OBJH   = 16,
  parameter int MAXOBJ = 32,
  localparam int VSW   = $clog2(OBJH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            LHBL,
  input  logic [VW-1:0]   vrender,
  output logic [OBJW-1:0] oam_addr,
  input  logic            oam_en,
  input  logic [VW-1:0]   oam_y,
  input  logic [HW-1:0]   oam_x,
  input  logic [CW-1:0]   oam_code,
  input  logic [3:0]      oam_attr,
  output logic            draw,
  input  logic            draw_busy,
  output logic [HW-1:0]   draw_x,
  output logic [CW-1:0]   draw_code,
  output logic [3:0]      draw_attr,
  output logic [VSW-1:0]  draw_vsub,
  output logic            done,
  output logic            overflow
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    CMP   = 3'd2,
    ISSUE = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [OBJW-1:0] LAST_IDX = {OBJW{1'b1}};
  localparam logic [VW:0]     OBJH_V   = (VW+1)'(OBJH);
  localparam logic [OBJW:0]   MAX_V    = (OBJW+1)'(MAXOBJ);

  state_t        state, state_nx;
  logic          lhbl_l;
  logic          start;
  logic [OBJW:0] cnt;
  logic [VW-1:0] vsub;
  logic          hit;
  logic          last;
  logic          addr_clr, addr_inc, latch, issue, set_done, set_ovf;

  // A falling edge of LHBL between two clocks starts a new scan
  assign start = lhbl_l & ~LHBL;
  // Row inside the object, modulo the vertical range so tall objects wrap
  assign vsub  = vrender - oam_y;
  assign hit   = oam_en && ({1'b0, vsub} < OBJH_V);
  assign last  = (oam_addr == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and datapath strobes; a start event overrides any state
  always_comb begin
    state_nx = state;
    addr_clr = 1'b0;
    addr_inc = 1'b0;
    latch    = 1'b0;
    issue    = 1'b0;
    set_done = 1'b0;
    set_ovf  = 1'b0;
    if (start) begin
      addr_clr = 1'b1;
      state_nx = ADDR;
    end else begin
      case (state)
        IDLE: state_nx = IDLE;
        ADDR: state_nx = CMP;
        CMP: begin
          if (hit) begin
            if (cnt == MAX_V) begin
              set_ovf  = 1'b1;
              set_done = 1'b1;
              state_nx = DONE;
            end else begin
              latch    = 1'b1;
              state_nx = ISSUE;
            end
          end else if (last) begin
            set_done = 1'b1;
            state_nx = DONE;
          end else begin
            addr_inc = 1'b1;
            state_nx = ADDR;
          end
        end
        ISSUE: begin
          if (!draw_busy) begin
            issue    = 1'b1;
            state_nx = HOLD;
          end
        end
        HOLD: begin
          if (last) begin
            set_done = 1'b1;
            state_nx = DONE;
          end else begin
            addr_inc = 1'b1;
            state_nx = ADDR;
          end
        end
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Blank edge detector; idles high so a low LHBL out of reset counts as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lhbl_l <= 1'b1;
    else        lhbl_l <= LHBL;
  end

  // OAM address walker and per-line hit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oam_addr <= '0;
      cnt      <= '0;
    end else begin
      if (addr_clr)      oam_addr <= '0;
      else if (addr_inc) oam_addr <= oam_addr + 1'b1;
      if (addr_clr)      cnt <= '0;
      else if (latch)    cnt <= cnt + 1'b1;
    end
  end

  // Draw request: registered one-cycle pulse; payload holds between requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      draw      <= 1'b0;
      draw_x    <= '0;
      draw_code <= '0;
      draw_attr <= '0;
      draw_vsub <= '0;
    end else begin
      draw <= issue;
      if (latch) begin
        draw_x    <= oam_x;
        draw_code <= oam_code;
        draw_attr <= oam_attr;
        draw_vsub <= vsub[VSW-1:0];
      end
    end
  end

  // Line status flags: cleared on scan start, set when the scan ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (addr_clr) begin
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (set_done) done     <= 1'b1;
      if (set_ovf)  overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire
